// File: rtl/router_event_generator.sv
// router_event_generator: per-port event source for the statistics collector.
// Watches input and output flit traffic on one router port, tracks packet
// framing per virtual channel, and emits one registered event record per cycle
// together with sticky framing-violation flags.

package router_event_pkg;
  // Width of the bypass-count field in the shared event record. Instances
  // with SMART_NUM up to 255 fit; narrower counts are zero-extended.
  localparam int MAX_BNW = 8;

  typedef struct packed {
    logic               flit_wr_i;
    logic               pck_wr_i;
    logic               flit_wr_o;
    logic               pck_wr_o;
    logic               flit_in_bypassed;
    logic [MAX_BNW-1:0] bypassed_num;
  } router_event_t;
endpackage

module router_event_generator
  import router_event_pkg::*;
#(
  parameter int  V         = 4,
  parameter int  SMART_NUM = 0,
  localparam int BNw       = (SMART_NUM > 0) ? $clog2(SMART_NUM + 1) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flit_in_wr,
  input  logic           flit_in_hdr,
  input  logic           flit_in_tail,
  input  logic [V-1:0]   flit_in_vc,
  input  logic           flit_in_bypassed,
  input  logic [BNw-1:0] smart_hops_in,
  input  logic           flit_out_wr,
  input  logic           flit_out_hdr,
  output router_event_t  router_event,
  output logic           frame_err,
  output logic [V-1:0]   frame_err_vc
);

  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam logic [V-1:0]       ONE_V   = {{(V-1){1'b0}}, 1'b1};
  localparam logic [V-1:0]       ZERO_V  = {V{1'b0}};
  localparam logic [MAX_BNW-1:0] SAT_MAX = MAX_BNW'(SMART_NUM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } vc_state_t;

  vc_state_t     state_r [V];
  logic [BNw-1:0] hops_r [V];
  logic [V-1:0]  frame_err_vc_r;
  logic          frame_err_r;
  router_event_t router_event_r;

  logic               vc_ok_s;
  logic               vc_bad_s;
  logic [VW-1:0]      vc_idx_s;
  logic [V-1:0]       hit_s;
  logic [V-1:0]       err_vc_new_s;
  logic [BNw-1:0]     hop_sel_s;
  logic [MAX_BNW-1:0] hop_ext_s;
  logic [MAX_BNW-1:0] hop_sat_s;
  router_event_t      ev_next_s;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [V-1:0] x);
    return (x != ZERO_V) && ((x & (x - ONE_V)) == ZERO_V);
  endfunction

  // Decode the addressed VC and detect framing violations for this flit.
  always_comb begin
    vc_ok_s  = is_onehot(flit_in_vc);
    vc_bad_s = flit_in_wr & ~vc_ok_s;
    vc_idx_s = {VW{1'b0}};
    for (int v = 0; v < V; v++) begin
      if (flit_in_vc[v]) begin
        vc_idx_s = VW'(v);
      end else begin
        vc_idx_s = vc_idx_s;
      end
    end
    for (int v = 0; v < V; v++) begin
      hit_s[v] = flit_in_wr & vc_ok_s & flit_in_vc[v];
      if (state_r[v] == IDLE) begin
        err_vc_new_s[v] = hit_s[v] & ~flit_in_hdr;
      end else begin
        err_vc_new_s[v] = hit_s[v] & flit_in_hdr;
      end
    end
  end

  // Pick the hop count for this flit (header carries it, others use the held value) and saturate.
  always_comb begin
    if (flit_in_hdr) begin
      hop_sel_s = smart_hops_in;
    end else if (vc_ok_s) begin
      hop_sel_s = hops_r[vc_idx_s];
    end else begin
      hop_sel_s = {BNw{1'b0}};
    end
    hop_ext_s = MAX_BNW'(hop_sel_s);
    if (hop_ext_s > SAT_MAX) begin
      hop_sat_s = SAT_MAX;
    end else begin
      hop_sat_s = hop_ext_s;
    end
  end

  // Assemble next-cycle event record; bypass fields are meaningless without SMART.
  always_comb begin
    ev_next_s.flit_wr_i = flit_in_wr;
    ev_next_s.pck_wr_i  = flit_in_wr & flit_in_hdr;
    ev_next_s.flit_wr_o = flit_out_wr;
    ev_next_s.pck_wr_o  = flit_out_wr & flit_out_hdr;
    if (SMART_NUM == 0) begin
      ev_next_s.flit_in_bypassed = 1'b0;
      ev_next_s.bypassed_num     = {MAX_BNW{1'b0}};
    end else begin
      ev_next_s.flit_in_bypassed = flit_in_wr & flit_in_bypassed;
      if (flit_in_wr && !flit_in_bypassed) begin
        ev_next_s.bypassed_num = hop_sat_s;
      end else begin
        ev_next_s.bypassed_num = {MAX_BNW{1'b0}};
      end
    end
  end

  // Per-VC framing FSMs, held hop counts and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        state_r[v] <= IDLE;
        hops_r[v]  <= {BNw{1'b0}};
      end
      frame_err_vc_r <= ZERO_V;
      frame_err_r    <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        if (hit_s[v]) begin
          case (state_r[v])
            IDLE: begin
              if (flit_in_hdr && !flit_in_tail) begin
                state_r[v] <= BODY;
                hops_r[v]  <= smart_hops_in;
              end else begin
                state_r[v] <= IDLE;
              end
            end
            BODY: begin
              if (flit_in_hdr) begin
                hops_r[v]  <= smart_hops_in;
                state_r[v] <= flit_in_tail ? IDLE : BODY;
              end else if (flit_in_tail) begin
                state_r[v] <= IDLE;
              end else begin
                state_r[v] <= BODY;
              end
            end
            default: state_r[v] <= IDLE;
          endcase
        end
      end
      frame_err_vc_r <= frame_err_vc_r | err_vc_new_s;
      frame_err_r    <= frame_err_r | (|err_vc_new_s) | vc_bad_s;
    end
  end

  // Register the event record so every field lags its inputs by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      router_event_r <= '{default: 1'b0};
    end else begin
      router_event_r <= ev_next_s;
    end
  end

  assign router_event = router_event_r;
  assign frame_err    = frame_err_r;
  assign frame_err_vc = frame_err_vc_r;

endmodule

// File: tb/tb_router_event_generator.sv
// Testbench for router_event_generator: directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a
// packet-level reference model.
module tb_router_event_generator;
  import router_event_pkg::*;

  localparam int SN = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, hdr, tail, byp, owr, ohdr;
  logic [3:0] vc;
  logic [2:0] hops;

  router_event_t ev5, ev0;
  logic          ferr5, ferr0;
  logic [3:0]    fvc5, fvc0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  router_event_generator #(.V(4), .SMART_NUM(SN)) u_dut (
    .clk(clk), .reset(reset), .flit_in_wr(wr), .flit_in_hdr(hdr),
    .flit_in_tail(tail), .flit_in_vc(vc), .flit_in_bypassed(byp),
    .smart_hops_in(hops), .flit_out_wr(owr), .flit_out_hdr(ohdr),
    .router_event(ev5), .frame_err(ferr5), .frame_err_vc(fvc5));

  router_event_generator #(.V(4), .SMART_NUM(0)) u_dut0 (
    .clk(clk), .reset(reset), .flit_in_wr(wr), .flit_in_hdr(hdr),
    .flit_in_tail(tail), .flit_in_vc(vc), .flit_in_bypassed(byp),
    .smart_hops_in(hops[0]), .flit_out_wr(owr), .flit_out_hdr(ohdr),
    .router_event(ev0), .frame_err(ferr0), .frame_err_vc(fvc0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit         in_pkt [4];
  int         held   [4];
  logic [3:0] m_err_vc;
  bit         m_err;
  bit         m_valid = 0;
  logic [12:0] exp_ev5, exp_ev0;   // {fwi,pwi,fwo,pwo,byp,bnum[7:0]}

  always @(posedge clk) begin
    int n, idx, h, b;
    m_valid = 1;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin in_pkt[i] = 0; held[i] = 0; end
      m_err_vc = 4'b0; m_err = 0; exp_ev5 = 13'b0; exp_ev0 = 13'b0;
    end else begin
      n = $countones(vc);
      idx = 0;
      for (int i = 0; i < 4; i++) if (vc[i]) idx = i;
      if (hdr) h = hops; else if (n == 1) h = held[idx]; else h = 0;
      b = (wr && !byp) ? ((h > SN) ? SN : h) : 0;
      exp_ev5 = {wr, wr & hdr, owr, owr & ohdr, wr & byp, 8'(b)};
      exp_ev0 = {wr, wr & hdr, owr, owr & ohdr, 1'b0, 8'b0};
      if (wr) begin
        if (n != 1) m_err = 1;
        else if (!in_pkt[idx]) begin
          if (!hdr) m_err_vc[idx] = 1'b1;
          else if (!tail) begin in_pkt[idx] = 1; held[idx] = hops; end
        end else begin
          if (hdr) begin m_err_vc[idx] = 1'b1; held[idx] = hops; in_pkt[idx] = !tail; end
          else if (tail) in_pkt[idx] = 0;
        end
      end
      if (m_err_vc != 4'b0) m_err = 1;
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("event_s5", 32'(ev5), 32'(exp_ev5));
      chk("ferr_s5",  32'(ferr5), 32'(m_err));
      chk("fvc_s5",   32'(fvc5), 32'(m_err_vc));
      chk("event_s0", 32'(ev0), 32'(exp_ev0));
      chk("ferr_s0",  32'(ferr0), 32'(m_err));
      chk("fvc_s0",   32'(fvc0), 32'(m_err_vc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic flit(input int v, input bit h, input bit t, input int hp,
                      input bit bp, input bit ow, input bit oh);
    wr = 1'b1; hdr = h; tail = t; vc = 4'(1 << v); hops = 3'(hp);
    byp = bp; owr = ow; ohdr = oh;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    wr = 1'b0; hdr = 1'b0; tail = 1'b0; vc = 4'b0; hops = 3'b0;
    byp = 1'b0; owr = 1'b0; ohdr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; idle(n); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    chk("reset_event", 32'(ev5), 32'd0);
    chk("reset_ferr", 32'({ferr5, fvc5}), 32'd0);
    reset = 1'b0;
    idle(1);

    // 4-flit packet on VC0, hops=2
    flit(0, 1, 0, 2, 0, 0, 0);
    chk("t1_hdr_pck", 32'(ev5.pck_wr_i), 32'd1);
    chk("t1_hdr_bn", 32'(ev5.bypassed_num), 32'd2);
    flit(0, 0, 0, 0, 0, 0, 0);
    chk("t1_body_pck", 32'(ev5.pck_wr_i), 32'd0);
    flit(0, 0, 0, 0, 0, 0, 0);
    flit(0, 0, 1, 0, 0, 0, 0);
    chk("t1_tail_bn", 32'(ev5.bypassed_num), 32'd2);
    chk("t1_tail_fwi", 32'(ev5.flit_wr_i), 32'd1);
    idle(1);
    chk("t1_ferr", 32'(ferr5), 32'd0);
    chk("t1_idle_fwi", 32'(ev5.flit_wr_i), 32'd0);

    // single-flit then 3-flit packet on VC2
    flit(2, 1, 1, 1, 0, 0, 0);
    chk("t2_single_bn", 32'(ev5.bypassed_num), 32'd1);
    flit(2, 1, 0, 4, 0, 0, 0);
    flit(2, 0, 0, 0, 0, 0, 0);
    flit(2, 0, 1, 0, 0, 0, 0);
    chk("t2_tail_bn", 32'(ev5.bypassed_num), 32'd4);
    idle(1);
    chk("t2_ferr", 32'(ferr5), 32'd0);

    // interleaved VC0 / VC1, VC1 saturates at SMART_NUM
    flit(0, 1, 0, 1, 0, 0, 0);
    flit(1, 1, 0, 7, 0, 0, 0);
    chk("t3_sat_hdr", 32'(ev5.bypassed_num), 32'd5);
    flit(0, 0, 0, 0, 0, 0, 0);
    chk("t3_vc0_body", 32'(ev5.bypassed_num), 32'd1);
    flit(1, 0, 0, 0, 0, 0, 0);
    chk("t3_sat_body", 32'(ev5.bypassed_num), 32'd5);
    flit(0, 0, 1, 0, 0, 0, 0);
    flit(1, 0, 1, 0, 0, 0, 0);
    idle(1);
    chk("t3_ferr", 32'(ferr5), 32'd0);

    // framing errors: body on idle VC3, header on busy VC1
    flit(1, 1, 0, 3, 0, 0, 0);
    flit(3, 0, 0, 0, 0, 0, 0);
    flit(1, 1, 0, 2, 0, 0, 0);
    idle(3);
    chk("t4_fvc", 32'(fvc5), 32'b1010);
    chk("t4_ferr", 32'(ferr5), 32'd1);
    do_reset(2);
    idle(1);
    chk("t4_cleared", 32'({ferr5, fvc5}), 32'd0);

    // bypassed input and output header in the same cycle
    flit(0, 1, 1, 3, 1, 1, 1);
    chk("t5_event", 32'(ev5), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}));
    chk("t5_s0_byp", 32'(ev0.flit_in_bypassed), 32'd0);
    idle(1);

    // reset mid-packet, then a tail on VC0
    flit(0, 1, 0, 2, 0, 0, 0);
    do_reset(2);
    chk("t6_rst_event", 32'(ev5), 32'd0);
    flit(0, 0, 1, 0, 0, 0, 0);
    chk("t6_fvc", 32'(fvc5), 32'b0001);
    idle(1);

    // randomized traffic
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 15);
      wr   = ($urandom_range(0, 3) != 0);
      vc   = (r < 13) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      hdr  = ($urandom_range(0, 2) == 0);
      tail = ($urandom_range(0, 2) == 0);
      hops = 3'($urandom_range(0, 7));
      byp  = ($urandom_range(0, 3) == 0);
      owr  = 1'($urandom_range(0, 1));
      ohdr = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
